// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared FSM encodings, channel codes and clamp width for adc_sampler
package adc_pkg;

    localparam int CLAMP_W = 12;

    localparam logic [1:0] CH0 = 2'b00;
    localparam logic [1:0] CH1 = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TRIGGER    = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_ACCUM      = 3'd4,
        ST_PUBLISH    = 3'd5,
        ST_RELEASE    = 3'd6
    } state_t;

endpackage

// File: rtl/adc_clamp.sv
// rtl/adc_clamp.sv - signed 16-bit adc result to unsigned 12-bit millivolts
module adc_clamp
    import adc_pkg::*;
(
    input  logic [15:0]        sample_i,
    output logic [CLAMP_W-1:0] mv_o
);

    logic unused_lsbs;
    assign unused_lsbs = ^sample_i[2:0];

    // 125 uV per LSB, so dropping three bits gives millivolts; negatives floor at zero
    assign mv_o = sample_i[15] ? '0 : sample_i[14:3];

endmodule

// File: rtl/adc_sampler.sv
// rtl/adc_sampler.sv - two-channel adc sequencer with averaging (ADC_SAMPLER_AVG_EN) and timeout
module adc_sampler
    import adc_pkg::*;
#(
    parameter int unsigned AVG_LOG2       = 2,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2700000
) (
    input  logic                clk,
    input  logic                resetN,
    output logic                adcEnable,
    output logic [1:0]          adcChannel,
    input  logic                adcDataReady,
    input  logic [15:0]         adcOutputData,
    output logic [CLAMP_W-1:0]  voltageCh0,
    output logic [CLAMP_W-1:0]  voltageCh1,
    output logic [15:0]         rawCh0,
    output logic [15:0]         rawCh1,
    output logic                sampleValid,
    output logic                sampleChannel,
    output logic                timeoutError
);

    localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

    state_t             state_q;
    logic               adc_enable_q;
    logic [1:0]         adc_channel_q;
    logic [CLAMP_W-1:0] voltage0_q;
    logic [CLAMP_W-1:0] voltage1_q;
    logic [15:0]        raw0_q;
    logic [15:0]        raw1_q;
    logic               sample_valid_q;
    logic               sample_channel_q;
    logic               timeout_error_q;
    logic [15:0]        sample_q;
    logic [23:0]        tmo_q;

    logic [CLAMP_W-1:0] clamp_mv;
    logic [CLAMP_W-1:0] pub_mv;
    logic [1:0]         next_channel_d;
    logic               cur_ch;

    adc_clamp u_clamp (
        .sample_i (sample_q),
        .mv_o     (clamp_mv)
    );

    assign next_channel_d = (adc_channel_q == CH0) ? CH1 : CH0;
    assign cur_ch         = adc_channel_q[0];

`ifdef ADC_SAMPLER_AVG_EN
    localparam int         ACC_W    = CLAMP_W + int'(AVG_LOG2);
    localparam logic [4:0] CNT_LAST = 5'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] accum_q;
    logic [4:0]       count_q;

    assign pub_mv = accum_q[ACC_W-1:AVG_LOG2];
`else
    logic unused_avg;
    assign unused_avg = ^AVG_LOG2;
    assign pub_mv     = clamp_mv;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q          <= ST_IDLE;
            adc_enable_q     <= 1'b0;
            adc_channel_q    <= CH0;
            voltage0_q       <= '0;
            voltage1_q       <= '0;
            raw0_q           <= '0;
            raw1_q           <= '0;
            sample_valid_q   <= 1'b0;
            sample_channel_q <= 1'b0;
            timeout_error_q  <= 1'b0;
            sample_q         <= '0;
            tmo_q            <= '0;
`ifdef ADC_SAMPLER_AVG_EN
            accum_q          <= '0;
            count_q          <= '0;
`endif
        end else begin
            sample_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: state_q <= ST_TRIGGER;
                ST_TRIGGER: begin
                    adc_enable_q <= 1'b1;
                    tmo_q        <= '0;
                    state_q      <= ST_WAIT_START;
                end
                // a high ready here is the previous result still on the bus
                ST_WAIT_START: begin
                    if (!adcDataReady) begin
                        tmo_q   <= tmo_q + 24'd1;
                        state_q <= ST_WAIT_READY;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        tmo_q <= tmo_q + 24'd1;
                    end
                end
                ST_WAIT_READY: begin
                    if (adcDataReady) begin
                        sample_q <= adcOutputData;
                        state_q  <= ST_ACCUM;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_RELEASE;
                    end else begin
                        tmo_q <= tmo_q + 24'd1;
                    end
                end
                ST_ACCUM: begin
                    adc_enable_q <= 1'b0;
                    if (cur_ch) raw1_q <= sample_q;
                    else        raw0_q <= sample_q;
`ifdef ADC_SAMPLER_AVG_EN
                    accum_q <= accum_q + ACC_W'(clamp_mv);
                    if (count_q == CNT_LAST) begin
                        state_q <= ST_PUBLISH;
                    end else begin
                        count_q <= count_q + 5'd1;
                        state_q <= ST_TRIGGER;
                    end
`else
                    state_q <= ST_PUBLISH;
`endif
                end
                ST_PUBLISH: begin
                    if (cur_ch) voltage1_q <= pub_mv;
                    else        voltage0_q <= pub_mv;
                    sample_valid_q   <= 1'b1;
                    sample_channel_q <= cur_ch;
                    adc_channel_q    <= next_channel_d;
`ifdef ADC_SAMPLER_AVG_EN
                    accum_q          <= '0;
                    count_q          <= '0;
`endif
                    state_q          <= ST_TRIGGER;
                end
                ST_RELEASE: begin
                    adc_enable_q    <= 1'b0;
                    timeout_error_q <= 1'b1;
                    adc_channel_q   <= next_channel_d;
`ifdef ADC_SAMPLER_AVG_EN
                    accum_q         <= '0;
                    count_q         <= '0;
`endif
                    state_q         <= ST_TRIGGER;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign adcEnable     = adc_enable_q;
    assign adcChannel    = adc_channel_q;
    assign voltageCh0    = voltage0_q;
    assign voltageCh1    = voltage1_q;
    assign rawCh0        = raw0_q;
    assign rawCh1        = raw1_q;
    assign sampleValid   = sample_valid_q;
    assign sampleChannel = sample_channel_q;
    assign timeoutError  = timeout_error_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb/tb_adc_sampler.sv - self-checking bench for adc_sampler with adc driver model and scoreboard
module tb_adc_sampler;

`ifdef ADC_SAMPLER_AVG_EN
    localparam int N = 4;
`else
    localparam int N = 1;
`endif

    logic        clk;
    logic        resetN;
    logic        adcEnable;
    logic [1:0]  adcChannel;
    logic        adcDataReady;
    logic [15:0] adcOutputData;
    logic [11:0] voltageCh0;
    logic [11:0] voltageCh1;
    logic [15:0] rawCh0;
    logic [15:0] rawCh1;
    logic        sampleValid;
    logic        sampleChannel;
    logic        timeoutError;

    adc_sampler #(
        .AVG_LOG2       (2),
        .TIMEOUT_CYCLES (24'd100)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .adcEnable     (adcEnable),
        .adcChannel    (adcChannel),
        .adcDataReady  (adcDataReady),
        .adcOutputData (adcOutputData),
        .voltageCh0    (voltageCh0),
        .voltageCh1    (voltageCh1),
        .rawCh0        (rawCh0),
        .rawCh1        (rawCh1),
        .sampleValid   (sampleValid),
        .sampleChannel (sampleChannel),
        .timeoutError  (timeoutError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int pub_seen  = 0;
    int req_count = 0;
    int last_rise_cyc = 0;
    int max_delay = 2;
    bit chk_ch    = 1'b0;
    logic [1:0] last_req_ch;
    logic [15:0] data_q[$];

    typedef struct {
        int          ch;
        int          mv;
        logic [15:0] raw;
    } pub_t;

    pub_t exp_pub[$];
    int   pend_sum[2];
    int   pend_cnt[2];
    int   exp_req_ch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp_ref(input logic [15:0] d);
        if (d >= 16'h8000) return 0;
        return int'(d) / 8;
    endfunction

    function automatic void model_reset();
        exp_pub.delete();
        pend_sum[0] = 0; pend_sum[1] = 0;
        pend_cnt[0] = 0; pend_cnt[1] = 0;
        exp_req_ch  = 0;
    endfunction

    // every N samples on one channel produce one truncated mean, then the other channel is served
    function automatic void model_sample(input int ch, input logic [15:0] d);
        pub_t p;
        pend_sum[ch] += clamp_ref(d);
        pend_cnt[ch]++;
        if (pend_cnt[ch] == N) begin
            p.ch  = ch;
            p.mv  = pend_sum[ch] / N;
            p.raw = d;
            exp_pub.push_back(p);
            pend_sum[ch] = 0;
            pend_cnt[ch] = 0;
            exp_req_ch   = 1 - ch;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // adc driver: accept request, go busy, return the next queued value; stall when queue empty
    localparam int D_IDLE = 0, D_DELAY = 1, D_BUSY = 2;
    int  dstate = D_IDLE;
    int  dcnt   = 0;
    bit  served = 1'b0;
    logic [1:0] req_ch = 2'b00;

    initial begin
        adcDataReady  = 1'b1;
        adcOutputData = 16'h0000;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                adcDataReady = 1'b1;
                dstate       = D_IDLE;
                served       = 1'b0;
            end else begin
                case (dstate)
                    D_IDLE: begin
                        if (!adcEnable) served = 1'b0;
                        else if (!served) begin
                            req_count++;
                            req_ch      = adcChannel;
                            last_req_ch = adcChannel;
                            if (chk_ch) check("req_channel", 32'(adcChannel), 32'(exp_req_ch));
                            dcnt   = $urandom_range(0, max_delay);
                            dstate = D_DELAY;
                        end
                    end
                    D_DELAY: begin
                        if (!adcEnable) dstate = D_IDLE;
                        else if (dcnt == 0) begin
                            adcDataReady = 1'b0;
                            dcnt   = $urandom_range(1, 4);
                            dstate = D_BUSY;
                        end else dcnt--;
                    end
                    default: begin
                        if (!adcEnable) begin
                            adcDataReady = 1'b1;
                            dstate = D_IDLE;
                        end else if (dcnt > 0) dcnt--;
                        else if (data_q.size() > 0) begin
                            adcOutputData = data_q.pop_front();
                            adcDataReady  = 1'b1;
                            served        = 1'b1;
                            last_rise_cyc = cyc;
                            model_sample(int'(req_ch[0]), adcOutputData);
                            dstate = D_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    initial forever begin
        pub_t p;
        @(negedge clk);
        if (resetN && sampleValid) begin
            pub_seen++;
            if (exp_pub.size() == 0) check("unexpected_publish", 32'd1, 32'd0);
            else begin
                p = exp_pub.pop_front();
                check("pub_channel", 32'(sampleChannel), 32'(p.ch));
                check("pub_voltage", 32'(p.ch ? voltageCh1 : voltageCh0), 32'(p.mv));
                check("pub_raw", 32'(p.ch ? rawCh1 : rawCh0), 32'(p.raw));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        data_q.delete();
        model_reset();
        req_count = 0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_adcEnable"}, 32'(adcEnable), 32'd0);
        check({tag, "_adcChannel"}, 32'(adcChannel), 32'd0);
        check({tag, "_voltageCh0"}, 32'(voltageCh0), 32'd0);
        check({tag, "_voltageCh1"}, 32'(voltageCh1), 32'd0);
        check({tag, "_rawCh0"}, 32'(rawCh0), 32'd0);
        check({tag, "_rawCh1"}, 32'(rawCh1), 32'd0);
        check({tag, "_sampleValid"}, 32'(sampleValid), 32'd0);
        check({tag, "_sampleChannel"}, 32'(sampleChannel), 32'd0);
        check({tag, "_timeoutError"}, 32'(timeoutError), 32'd0);
    endtask

    typedef struct {
        logic [15:0] smp;
        logic [11:0] exp_mv;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int hi;
        int start;
        logic [15:0] d;

        vecs[0] = '{16'h2000, 12'd1024};
        vecs[1] = '{16'h0008, 12'd1};
        vecs[2] = '{16'hFFF0, 12'd0};
        vecs[3] = '{16'h7FF8, 12'd4095};
        vecs[4] = '{16'h8000, 12'd0};
        vecs[5] = '{16'h0007, 12'd0};
        vecs[6] = '{16'h7FFF, 12'd4095};
        vecs[7] = '{16'h1234, 12'd582};

        resetN = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        chk_ch = 1'b1;
        for (int v = 0; v < 8; v++) begin
            do_reset();
            for (int k = 0; k < N; k++) data_q.push_back(vecs[v].smp);
            ok = 1'b0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (sampleValid) begin ok = 1'b1; break; end
            end
            check("vec_publish_seen", 32'(ok), 32'd1);
            if (ok) begin
                check("vec_voltageCh0", 32'(voltageCh0), 32'(vecs[v].exp_mv));
                check("vec_rawCh0", 32'(rawCh0), 32'(vecs[v].smp));
                check("vec_sampleChannel", 32'(sampleChannel), 32'd0);
                check("vec_voltageCh1_untouched", 32'(voltageCh1), 32'd0);
                check("vec_latency", 32'(cyc - last_rise_cyc), 32'd3);
                @(negedge clk);
                check("vec_pulse_one_cycle", 32'(sampleValid), 32'd0);
                check("vec_channel_toggled", 32'(adcChannel), 32'd1);
            end
        end

        do_reset();
        data_q.push_back(16'h0008); data_q.push_back(16'h0010);
        data_q.push_back(16'h0018); data_q.push_back(16'h0020);
        start = pub_seen;
        for (int c = 0; c < 3000 && pub_seen < start + 4 / N; c++) @(negedge clk);
        check("trunc_publishes", 32'(pub_seen - start), 32'(4 / N));
        check("trunc_voltageCh0", 32'(voltageCh0), (N == 4) ? 32'd2 : 32'd3);

        do_reset();
        max_delay = 5;
        for (int i = 0; i < 24 * N; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 16'($urandom) | 16'h8000;
                1:       d = 16'($urandom_range(0, 63));
                default: d = 16'($urandom) & 16'h7FFF;
            endcase
            data_q.push_back(d);
        end
        start = pub_seen;
        for (int c = 0; c < 20000 && pub_seen < start + 24; c++) @(negedge clk);
        check("random_publishes", 32'(pub_seen - start), 32'd24);
        check("random_expected_drained", 32'(exp_pub.size()), 32'd0);
        check("random_no_timeout", 32'(timeoutError), 32'd0);

        chk_ch = 1'b0;
        max_delay = 2;
        do_reset();
        start = pub_seen;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (adcEnable) begin ok = 1'b1; break; end
        end
        check("tmo_request_seen", 32'(ok), 32'd1);
        hi = 1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (adcEnable) hi++;
            else break;
        end
        check("tmo_enable_len_in_range", 32'(hi >= 100 && hi <= 102), 32'd1);
        check("tmo_error_set", 32'(timeoutError), 32'd1);
        check("tmo_channel_toggled", 32'(adcChannel), 32'd1);
        check("tmo_no_publish", 32'(pub_seen - start), 32'd0);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (adcEnable) begin ok = 1'b1; break; end
        end
        check("tmo_next_request", 32'(ok), 32'd1);
        check("tmo_next_channel", 32'(adcChannel), 32'd1);
        check("tmo_error_sticky", 32'(timeoutError), 32'd1);

        chk_ch = 1'b1;
        do_reset();
        check("tmo_error_cleared_by_reset", 32'(timeoutError), 32'd0);
        for (int k = 0; k < N + 2; k++) data_q.push_back(16'h1000);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req_count == N + 3 && !adcDataReady) begin ok = 1'b1; break; end
        end
        check("midconv_reached", 32'(ok), 32'd1);
        check("midconv_voltageCh0_before", 32'(voltageCh0), 32'd512);
        check("midconv_enable_before", 32'(adcEnable), 32'd1);
        #2;
        resetN = 1'b0;
        #1;
        check_all_zero("midconv");
        @(negedge clk);
        data_q.delete();
        model_reset();
        req_count = 0;
        @(negedge clk);
        resetN = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (req_count >= 1) begin ok = 1'b1; break; end
        end
        check("midconv_restart_request", 32'(ok), 32'd1);
        check("midconv_restart_channel", 32'(last_req_ch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
